fetch_prefetch_queue: RTL and testbench

Parametrised instruction-fetch front end: owns the program counter, issues sequential word requests to instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs in a DEPTH-entry FIFO for decode. Supports multiple outstanding requests, redirects from branch/jump resolution with flush and discard of stale responses, and decode back-pressure. Sits between instruction memory and the decode stage, replacing the single-register PC/fetch pair.

---
 rtl/fetch_prefetch_queue_pkg.sv | 15 +
 rtl/fetch_prefetch_queue_fifo.sv | 56 +++++
 rtl/fetch_prefetch_queue.sv | 117 +++++++++++
 tb/tb_fetch_prefetch_queue.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
package fetch_prefetch_queue_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word;

  typedef struct packed {
    word pc;
    word inst;
  } fetch_entry_t;

  localparam word RESET_PC_DEFAULT = '0;

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// fetch_fifo: DEPTH-entry registered FIFO holding fetched {pc, inst} entries.
module fetch_fifo
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1),
  parameter type entry_t = fetch_entry_t
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: PC, credit-limited memory requests, redirect/drop control.
// Optional FETCH_PERF_EN adds perf_fetched / perf_dropped / perf_stall counters.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned       XLEN     = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [XLEN-1:0]   RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clock,
  input  logic            reset,
`ifdef FETCH_PERF_EN
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_dropped,
  output logic [31:0]     perf_stall,
`endif
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_inst,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_pc_4
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   rsp_pc;
  logic [XLEN-1:0]   target;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              issue_ok;
  logic              req_fire;
  logic              discard;
  logic              push;
  logic              pop;
  logic [2*XLEN-1:0] head;

  assign target   = redirect_addr & ~XLEN'(3);
  // Credits cover both buffered entries and requests still in flight.
  assign issue_ok = !full && ((SUM_W'(inflight) + SUM_W'(count)) < SUM_W'(DEPTH));

  assign mem_req_valid = !reset && !redirect_valid && issue_ok;
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign discard       = mem_rsp_valid && (redirect_valid || (drop_cnt != '0));
  assign push          = mem_rsp_valid && !discard;
  assign pop           = dec_valid && dec_ready;

  assign dec_valid = !empty;
  assign dec_pc    = head[2*XLEN-1:XLEN];
  assign dec_inst  = head[XLEN-1:0];
  assign dec_pc_4  = dec_pc + XLEN'(4);

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .entry_t (logic [2*XLEN-1:0])
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({rsp_pc, mem_rsp_data}),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // Redirect retargets both PCs and marks everything still in flight as stale.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CNT_W'(req_fire) - CNT_W'(mem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= target;
        rsp_pc   <= target;
        drop_cnt <= inflight - CNT_W'(mem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (push) rsp_pc <= rsp_pc + XLEN'(4);
        if (mem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_stall   <= '0;
    end else begin
      if (push) perf_fetched <= perf_fetched + 32'd1;
      if (discard) perf_dropped <= perf_dropped + 32'd1;
      if (dec_ready && !dec_valid) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed phases, fixed-latency memory, decode scoreboard.
`timescale 1ns/1ps
module tb_fetch_prefetch_queue;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_addr;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_inst;
  logic [XLEN-1:0] dec_pc;
  logic [XLEN-1:0] dec_pc_4;
`ifdef FETCH_PERF_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_dropped;
  logic [31:0]     perf_stall;
`endif

  always #5 clock = ~clock;

  fetch_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock          (clock),
    .reset          (reset),
`ifdef FETCH_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped),
    .perf_stall     (perf_stall),
`endif
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .dec_pc_4       (dec_pc_4)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          ep;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } dexp_t;

  int          checks = 0;
  int          errors = 0;
  int          lat    = 1;
  int          epoch  = 0;
  int          cyc    = 0;
  int          issued;
  mreq_t       pend[$];
  dexp_t       exp_dec[$];
  mreq_t       r_cur;
  dexp_t       e_cur;
  logic [31:0] exp_fetch = 32'h0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Memory: in-order, fixed latency; epochs mark responses made stale by redirect/reset.
  initial begin
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(negedge clock);
      cyc++;
      #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      if (reset) begin
        pend.delete();
        exp_dec.delete();
      end else begin
        if (redirect_valid) begin
          epoch++;
          exp_dec.delete();
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          r_cur = pend.pop_front();
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = inst_of(r_cur.addr);
          if (r_cur.ep == epoch) exp_dec.push_back('{r_cur.addr, inst_of(r_cur.addr)});
        end
      end
      #1;
      if (!reset && mem_req_valid && mem_req_ready)
        pend.push_back('{mem_req_addr, cyc + lat, epoch});
    end
  end

  // Monitor: request address sequence and decode pops against the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        exp_fetch = 32'h0;
      end else begin
        if (redirect_valid) begin
          check("req_during_redirect", 32'(mem_req_valid), 32'h0);
          exp_fetch = redirect_addr & ~32'h3;
        end else if (mem_req_valid && mem_req_ready) begin
          check("req_addr", mem_req_addr, exp_fetch);
          exp_fetch = exp_fetch + 32'd4;
        end
        if (dec_valid && dec_ready && !redirect_valid) begin
          if (exp_dec.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dec_pop actual_pc=0x%08h expected=no_entry", dec_pc);
          end else begin
            e_cur = exp_dec.pop_front();
            check("dec_pc", dec_pc, e_cur.pc);
            check("dec_inst", dec_inst, e_cur.inst);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    dec_ready      = 1'b0;

    // Reset values
    step(3); #3;
    check("rst_req_valid", 32'(mem_req_valid), 32'h0);
    check("rst_req_addr", mem_req_addr, 32'h0);
    check("rst_dec_valid", 32'(dec_valid), 32'h0);
    check("rst_dec_inst", dec_inst, 32'h0);
    check("rst_dec_pc", dec_pc, 32'h0);
    check("rst_dec_pc_4", dec_pc_4, 32'h4);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetched", perf_fetched, 32'h0);
`endif

    // Streaming with 1-cycle memory
    mem_req_ready = 1'b1;
    dec_ready     = 1'b1;
    lat           = 1;
    step(1); reset = 1'b0; #3;
    check("a_first_valid", 32'(mem_req_valid), 32'h1);
    check("a_first_addr", mem_req_addr, 32'h0);
    step(2); #3;
    check("a_dec_valid_c2", 32'(dec_valid), 32'h1);
    check("a_dec_pc_c2", dec_pc, 32'h0);
    step(1); #3;
    check("a_dec_pc_c3", dec_pc, 32'h4);
    check("a_dec_pc_4_c3", dec_pc_4, 32'h8);
    step(8);

    // Reset with a request in flight, then back-pressure fills the queue
    reset = 1'b1; #3;
    check("b_rst_dec_valid", 32'(dec_valid), 32'h0);
    check("b_rst_req_valid", 32'(mem_req_valid), 32'h0);
    step(1); dec_ready = 1'b0;
    step(1); reset = 1'b0; #3;
    issued = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_req_valid && mem_req_ready) issued++;
      step(1); #3;
    end
    check("b_issue_count", 32'(issued), 32'd4);
    check("b_full_no_req", 32'(mem_req_valid), 32'h0);
    check("b_full_head", dec_pc, 32'h0);
    step(1); dec_ready = 1'b1; #3;
    check("b_pop_cycle_no_req", 32'(mem_req_valid), 32'h0);
    step(1); dec_ready = 1'b0; #3;
    check("b_after_pop_valid", 32'(mem_req_valid), 32'h1);
    check("b_after_pop_addr", mem_req_addr, 32'h10);
    check("b_after_pop_head", dec_pc, 32'h4);
    step(1); #3;
    check("b_refull_no_req", 32'(mem_req_valid), 32'h0);
    step(3);

    // Reset with a full queue; restart from RESET_PC, 3-cycle memory, redirect
    reset = 1'b1; #3;
    check("c_rst_dec_valid", 32'(dec_valid), 32'h0);
    check("c_rst_dec_pc", dec_pc, 32'h0);
    lat       = 3;
    dec_ready = 1'b1;
    step(2); reset = 1'b0; #3;
    check("c_restart_valid", 32'(mem_req_valid), 32'h1);
    check("c_restart_addr", mem_req_addr, 32'h0);
    step(3); redirect_valid = 1'b1; redirect_addr = 32'h103; #3;
    check("c_redirect_no_req", 32'(mem_req_valid), 32'h0);
    step(1); redirect_valid = 1'b0; #3;
    check("c_new_valid", 32'(mem_req_valid), 32'h1);
    check("c_new_addr", mem_req_addr, 32'h100);
    step(3); #3;
    check("c_stale_dropped", 32'(dec_valid), 32'h0);
    step(1); #3;
    check("c_first_valid", 32'(dec_valid), 32'h1);
    check("c_first_pc", dec_pc, 32'h100);
`ifdef FETCH_PERF_EN
    check("c_perf_dropped", perf_dropped, 32'd3);
    check("c_perf_fetched", perf_fetched, 32'd1);
`endif
    step(6);

    // Redirect together with a response and a pop
    reset = 1'b1;
    lat   = 1;
    step(2); reset = 1'b0;
    step(3); redirect_valid = 1'b1; redirect_addr = 32'h200; #3;
    check("d_pre_dec_valid", 32'(dec_valid), 32'h1);
    check("d_pre_dec_pc", dec_pc, 32'h4);
    check("d_redirect_no_req", 32'(mem_req_valid), 32'h0);
    step(1); redirect_valid = 1'b0; #3;
    check("d_flushed", 32'(dec_valid), 32'h0);
    check("d_new_addr", mem_req_addr, 32'h200);
    step(2); #3;
    check("d_first_pc", dec_pc, 32'h200);
    step(4);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_addr = 32'hFFFF_FFFA;
    step(1); redirect_valid = 1'b0; #3;
    check("e_addr_fff8", mem_req_addr, 32'hFFFF_FFF8);
    step(2); #3;
    check("e_wrap_valid", 32'(mem_req_valid), 32'h1);
    check("e_wrap_addr", mem_req_addr, 32'h0);
    step(1); #3;
    check("e_pc_top", dec_pc, 32'hFFFF_FFFC);
    check("e_pc_4_wrap", dec_pc_4, 32'h0);

    // Drain and confirm every expected instruction was delivered
    step(1); mem_req_ready = 1'b0;
    step(8); #3;
    check("drain_dec_valid", 32'(dec_valid), 32'h0);
    check("scoreboard_left", 32'(exp_dec.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
